// File: rtl/cpu_run_controller.sv
// cpu_run_controller: single-clock sequencer that issues one-cycle cpu_enable strobes (step or paced run), CPU reset pulse, instruction count and PC breakpoint.
// Latency: step_req/tick sampled at edge N -> cpu_enable high N..N+1; breakpoint compare N+1..N+2, BREAK visible after N+2.
// Backpressure: none; events landing in an enable cycle, a breakpoint-hit cycle or a non-accepting state are dropped. Optional macro CPU_RUN_CONTROLLER_BREAKPOINT_EN.
module cpu_run_controller #(
    parameter int RESET_CYCLES = 2,
    parameter int COUNT_WIDTH  = 16,
    parameter int PC_WIDTH     = 32
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   soft_reset,
    input  logic                   step_req,
    input  logic                   run_mode,
    input  logic                   tick,
    input  logic [PC_WIDTH-1:0]    pc,
    input  logic [PC_WIDTH-1:0]    bp_addr,
    input  logic                   bp_enable,
    input  logic                   resume,
    output logic                   cpu_enable,
    output logic                   cpu_reset,
    output logic [COUNT_WIDTH-1:0] cycle_count,
    output logic                   halted,
    output logic [1:0]             state
);

    typedef enum logic [1:0] {
        ST_INIT  = 2'b00,
        ST_IDLE  = 2'b01,
        ST_RUN   = 2'b10,
        ST_BREAK = 2'b11
    } state_t;

    // Width of the INIT dwell counter; needs to hold RESET_CYCLES-1.
    localparam int                IW        = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [IW-1:0]     INIT_LAST = IW'(RESET_CYCLES - 1);

    state_t                 state_q;
    logic [IW-1:0]          init_cnt_q;
    logic                   cpu_reset_q;
    logic                   cpu_enable_q;
    logic                   cmp_q;        // high in the cycle right after an enable: pc is post-update
    logic [COUNT_WIDTH-1:0] count_q;
    logic                   halted_q;
    logic                   bp_hit;

`ifdef CPU_RUN_CONTROLLER_BREAKPOINT_EN
    // Breakpoint only looks at pc when it has just been advanced by an enable.
    assign bp_hit = cmp_q && bp_enable && (pc == bp_addr);
`else
    logic unused_bp;
    assign bp_hit    = 1'b0;
    assign unused_bp = ^{pc, bp_addr, bp_enable, resume, cmp_q};
`endif

    // Whole controller: state, INIT dwell, enable strobe, compare window and instruction count.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_INIT;
            init_cnt_q   <= '0;
            cpu_reset_q  <= 1'b1;
            cpu_enable_q <= 1'b0;
            cmp_q        <= 1'b0;
            count_q      <= '0;
            halted_q     <= 1'b0;
        end else begin
            // Enable is a strobe: cleared unless re-issued below.
            cpu_enable_q <= 1'b0;
            cmp_q        <= cpu_enable_q;
            if (cpu_enable_q) begin
                count_q <= count_q + 1'b1;
            end

            if (soft_reset) begin
                // Restart beats every other event, including a pending compare.
                state_q     <= ST_INIT;
                init_cnt_q  <= '0;
                cpu_reset_q <= 1'b1;
                cmp_q       <= 1'b0;
                count_q     <= '0;
                halted_q    <= 1'b0;
            end else begin
                case (state_q)
                    ST_INIT: begin
                        if (init_cnt_q == INIT_LAST) begin
                            state_q     <= ST_IDLE;
                            cpu_reset_q <= 1'b0;
                        end else begin
                            init_cnt_q <= init_cnt_q + 1'b1;
                        end
                    end
                    ST_IDLE: begin
                        if (bp_hit) begin
                            state_q  <= ST_BREAK;
                            halted_q <= 1'b1;
                        end else begin
                            // A step in the enable cycle itself is dropped (2-cycle spacing).
                            if (step_req && !cpu_enable_q) begin
                                cpu_enable_q <= 1'b1;
                            end
                            if (run_mode) begin
                                state_q <= ST_RUN;
                            end
                        end
                    end
                    ST_RUN: begin
                        if (bp_hit) begin
                            state_q  <= ST_BREAK;
                            halted_q <= 1'b1;
                        end else if (!run_mode) begin
                            state_q <= ST_IDLE;
                        end else if (tick && !cpu_enable_q) begin
                            cpu_enable_q <= 1'b1;
                        end
                    end
                    ST_BREAK: begin
`ifdef CPU_RUN_CONTROLLER_BREAKPOINT_EN
                        if (resume) begin
                            state_q  <= run_mode ? ST_RUN : ST_IDLE;
                            halted_q <= 1'b0;
                        end
`else
                        // Unreachable without the breakpoint feature; recover to IDLE.
                        state_q  <= ST_IDLE;
                        halted_q <= 1'b0;
`endif
                    end
                endcase
            end
        end
    end

    assign cpu_enable  = cpu_enable_q;
    assign cpu_reset   = cpu_reset_q;
    assign cycle_count = count_q;
    assign state       = state_q;
`ifdef CPU_RUN_CONTROLLER_BREAKPOINT_EN
    assign halted      = halted_q;
`else
    assign halted      = 1'b0;
    logic unused_halt;
    assign unused_halt = halted_q;
`endif

endmodule

// File: tb/tb_cpu_run_controller.sv
// tb_cpu_run_controller: directed scenarios plus randomized traffic, checked every cycle against a timeline model.
// Latency: outputs compared on each falling edge against the model state after the preceding rising edge.
// Backpressure: n/a.
module tb_cpu_run_controller;

    localparam int RC = 2;
`ifdef CPU_RUN_CONTROLLER_BREAKPOINT_EN
    localparam bit BP_EN = 1'b1;
`else
    localparam bit BP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        soft_reset = 1'b0;
    logic        step_req = 1'b0;
    logic        run_mode = 1'b0;
    logic        tick = 1'b0;
    logic [31:0] pc = 32'd0;
    logic [31:0] bp_addr = 32'd0;
    logic        bp_enable = 1'b0;
    logic        resume = 1'b0;
    logic        pc_clear = 1'b0;

    logic        en, crst, hlt;
    logic [15:0] cnt;
    logic [1:0]  st;
    logic        en_w, crst_w, hlt_w;
    logic [3:0]  cnt_w;
    logic [1:0]  st_w;

    int n_checks = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    cpu_run_controller #(.RESET_CYCLES(RC), .COUNT_WIDTH(16), .PC_WIDTH(32)) dut (
        .clock(clk), .reset_n(rst_n), .soft_reset(soft_reset), .step_req(step_req),
        .run_mode(run_mode), .tick(tick), .pc(pc), .bp_addr(bp_addr), .bp_enable(bp_enable),
        .resume(resume), .cpu_enable(en), .cpu_reset(crst), .cycle_count(cnt),
        .halted(hlt), .state(st)
    );

    cpu_run_controller #(.RESET_CYCLES(RC), .COUNT_WIDTH(4), .PC_WIDTH(32)) dut_w (
        .clock(clk), .reset_n(rst_n), .soft_reset(soft_reset), .step_req(step_req),
        .run_mode(run_mode), .tick(tick), .pc(pc), .bp_addr(bp_addr), .bp_enable(bp_enable),
        .resume(resume), .cpu_enable(en_w), .cpu_reset(crst_w), .cycle_count(cnt_w),
        .halted(hlt_w), .state(st_w)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- timeline model ----------------
    // Mode: 0 INIT, 1 IDLE, 2 RUN, 3 BREAK. Enables are tracked by the edge index that
    // issued them: high during [e, e+1), pc updated at e+1, breakpoint judged at e+2.
    int m_mode = 0;
    int m_init_left = RC;
    int m_count = 0;
    int m_last_en = -10;
    int m_cyc = 0;
    bit m_busy, m_hit;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_mode = 0; m_init_left = RC; m_count = 0; m_last_en = -10;
        end else begin
            m_busy = (m_last_en == m_cyc - 1);
            m_hit  = BP_EN && (m_last_en == m_cyc - 2) && bp_enable && (pc == bp_addr);
            if (m_busy) m_count++;
            if (soft_reset) begin
                m_mode = 0; m_init_left = RC; m_count = 0; m_last_en = -10;
            end else if (m_mode == 0) begin
                m_init_left--;
                if (m_init_left == 0) m_mode = 1;
            end else if (m_mode == 1) begin
                if (m_hit) m_mode = 3;
                else begin
                    if (step_req && !m_busy) m_last_en = m_cyc;
                    if (run_mode) m_mode = 2;
                end
            end else if (m_mode == 2) begin
                if (m_hit) m_mode = 3;
                else if (!run_mode) m_mode = 1;
                else if (tick && !m_busy) m_last_en = m_cyc;
            end else begin
                if (resume) m_mode = run_mode ? 2 : 1;
            end
        end
        // CPU stand-in: pc advances by 4 on every edge where an enable is high.
        if (pc_clear) pc <= 32'd0;
        else if (rst_n && (m_last_en == m_cyc - 1) && !m_busy) pc <= pc;
        if (!pc_clear && rst_n && m_busy) pc <= pc + 32'd4;
        m_cyc++;
    end

    // Per-cycle compare of both instances against the model.
    always @(negedge clk) begin
        logic [31:0] cnt_full;
        cnt_full = m_count;
        chk("state", {30'd0, st}, m_mode);
        chk("cpu_enable", {31'd0, en}, {31'd0, (m_last_en == m_cyc - 1)});
        chk("cpu_reset", {31'd0, crst}, {31'd0, (m_mode == 0)});
        chk("halted", {31'd0, hlt}, {31'd0, (m_mode == 3)});
        chk("cycle_count", {16'd0, cnt}, {16'd0, cnt_full[15:0]});
        chk("cycle_count_w4", {28'd0, cnt_w}, {28'd0, cnt_full[3:0]});
        chk("cpu_enable_w4", {31'd0, en_w}, {31'd0, (m_last_en == m_cyc - 1)});
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    int tick_gap = 0;

    initial begin
        // Reset sequence.
        cycles(3);
        chk("rst_state", {30'd0, st}, 32'd0);
        chk("rst_cpu_reset", {31'd0, crst}, 32'd1);
        chk("rst_enable", {31'd0, en}, 32'd0);
        chk("rst_count", {16'd0, cnt}, 32'd0);
        rst_n = 1'b1;
        cycles(1);
        chk("init_edge1_state", {30'd0, st}, 32'd0);
        chk("init_edge1_reset", {31'd0, crst}, 32'd1);
        cycles(1);
        chk("init_done_state", {30'd0, st}, 32'd1);
        chk("init_done_reset", {31'd0, crst}, 32'd0);
        chk("init_done_count", {16'd0, cnt}, 32'd0);

        // Stepping: three isolated requests.
        pc_clear = 1'b1; cycles(1); pc_clear = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step_req = 1'b1; cycles(1); step_req = 1'b0;
            chk("step_enable_hi", {31'd0, en}, 32'd1);
            cycles(1);
            chk("step_enable_lo", {31'd0, en}, 32'd0);
            cycles(8);
        end
        chk("step_count3", {16'd0, cnt}, 32'd3);

        // Back-to-back requests: second lands in the enable cycle and is dropped.
        step_req = 1'b1; cycles(2); step_req = 1'b0;
        cycles(3);
        chk("b2b_count", {16'd0, cnt}, 32'd4);

        // Free run: four ticks five cycles apart.
        run_mode = 1'b1; cycles(1);
        chk("run_state", {30'd0, st}, 32'd2);
        for (int i = 0; i < 4; i++) begin
            tick = 1'b1; cycles(1); tick = 1'b0;
            chk("run_tick_enable", {31'd0, en}, 32'd1);
            cycles(4);
        end
        chk("run_count", {16'd0, cnt}, 32'd8);
        chk("run_state2", {30'd0, st}, 32'd2);
        tick = 1'b1; run_mode = 1'b0; cycles(1); tick = 1'b0;
        chk("stop_tick_enable", {31'd0, en}, 32'd0);
        chk("stop_state", {30'd0, st}, 32'd1);
        cycles(2);
        chk("stop_count", {16'd0, cnt}, 32'd8);

        // Breakpoint at 0x10 with pc stepping by 4 from 0.
        pc_clear = 1'b1; cycles(1); pc_clear = 1'b0;
        bp_addr = 32'h10; bp_enable = 1'b1; run_mode = 1'b1;
        cycles(1);
        for (int i = 0; i < 6; i++) begin
            tick = 1'b1; cycles(1); tick = 1'b0;
            cycles(4);
        end
        chk("bp_halted", {31'd0, hlt}, BP_EN ? 32'd1 : 32'd0);
        chk("bp_state", {30'd0, st}, BP_EN ? 32'd3 : 32'd2);
        chk("bp_pc", pc, BP_EN ? 32'h10 : 32'h18);
        resume = 1'b1; cycles(1); resume = 1'b0;
        chk("resume_state", {30'd0, st}, 32'd2);
        chk("resume_halted", {31'd0, hlt}, 32'd0);
        tick = 1'b1; cycles(1); tick = 1'b0;
        cycles(4);
        chk("resume_pc", pc, BP_EN ? 32'h14 : 32'h1C);
        chk("resume_no_rebreak", {30'd0, st}, 32'd2);

        // soft_reset beats a simultaneous tick.
        soft_reset = 1'b1; tick = 1'b1; run_mode = 1'b0; bp_enable = 1'b0;
        cycles(1);
        soft_reset = 1'b0; tick = 1'b0;
        chk("soft_enable", {31'd0, en}, 32'd0);
        chk("soft_state", {30'd0, st}, 32'd0);
        chk("soft_count", {16'd0, cnt}, 32'd0);
        chk("soft_reset_hi", {31'd0, crst}, 32'd1);
        cycles(1);
        chk("soft_reset_hi2", {31'd0, crst}, 32'd1);
        cycles(1);
        chk("soft_reset_lo", {31'd0, crst}, 32'd0);
        chk("soft_idle", {30'd0, st}, 32'd1);

        // Wrap: 17 enables on the 4-bit counter instance.
        for (int i = 0; i < 17; i++) begin
            step_req = 1'b1; cycles(1); step_req = 1'b0;
            cycles(2);
        end
        chk("wrap_count_w4", {28'd0, cnt_w}, 32'd1);
        chk("wrap_count_16", {16'd0, cnt}, 32'd17);

        // Randomized traffic; the per-cycle compare does the checking.
        for (int i = 0; i < 4000; i++) begin
            step_req = ($urandom_range(0, 3) == 0);
            if (tick_gap == 0) begin
                tick = 1'b1;
                tick_gap = $urandom_range(2, 6);
            end else begin
                tick = 1'b0;
                tick_gap--;
            end
            if ($urandom_range(0, 40) == 0) run_mode = ~run_mode;
            resume = ($urandom_range(0, 11) == 0);
            soft_reset = ($urandom_range(0, 250) == 0);
            if ($urandom_range(0, 30) == 0) begin
                bp_enable = ($urandom_range(0, 3) != 0);
                bp_addr = pc + 32'($urandom_range(0, 3)) * 32'd4;
            end
            rst_n = ($urandom_range(0, 700) != 0);
            cycles(1);
        end
        step_req = 1'b0; tick = 1'b0; resume = 1'b0; soft_reset = 1'b0; rst_n = 1'b1;
        cycles(3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
